// File: rtl/adder_pkg.sv
// adder_pkg: shared states, frame sizes and line levels for the adder result UART transmitter
package adder_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, CARRY, STOP} state_t;
  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP = 1'b1;
endpackage

// File: rtl/adder_result_uart_tx_if.sv
// adder_result_uart_tx_if: adder result capture request and serial line status
interface adder_result_uart_tx_if import adder_pkg::*; ();
  logic ena;
  logic start;
  logic [DATA_BITS-1:0] sum;
  logic carry;
  logic tx;
  logic busy;
  logic done;
  modport master(output ena, start, sum, carry, input tx, busy, done);
  modport slave(input ena, start, sum, carry, output tx, busy, done);
endinterface

// File: rtl/adder_result_uart_tx_baud_tick_gen.sv
// baud_tick_gen: one-cycle tick at the end of each bit period while running
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_run,
  output logic o_tick
);
  logic [CNT_W-1:0] r_cnt;
  assign o_tick = i_run && r_cnt == CNT_W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk) begin
    if (rst || i_clear || !i_run || o_tick) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/adder_result_uart_tx.sv
// adder_result_uart_tx: sends {carry,sum} as an 11-bit LSB-first serial frame
module adder_result_uart_tx import adder_pkg::*; #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  adder_result_uart_tx_if.slave bus
);
  state_t r_state, w_state_n;
  logic [DATA_BITS:0] r_shreg, w_shreg_n;
  logic [2:0] r_idx, w_idx_n;
  logic r_tx, r_busy, r_done;
  logic w_tx_n, w_busy_n, w_done_n;
  logic w_tick, w_load, w_abort, w_shift;
  // a new frame may be loaded on the last edge of the stop bit, giving no idle gap
  assign w_load = bus.ena && bus.start && (r_state == IDLE || (r_state == STOP && w_tick));
  assign w_abort = !bus.ena && r_state != IDLE;
  assign w_shift = w_tick && r_state == DATA;
  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_tick (
    .clk(clk),
    .rst(rst),
    .i_clear(w_load || w_abort),
    .i_run(r_busy),
    .o_tick(w_tick)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_idx <= '0;
      r_tx <= LINE_IDLE;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_shreg <= w_shreg_n;
      r_idx <= w_idx_n;
      r_tx <= w_tx_n;
      r_busy <= w_busy_n;
      r_done <= w_done_n;
    end
  end
  always_comb begin
    w_state_n = !bus.ena ? IDLE :
                w_load ? START :
                !w_tick ? r_state :
                r_state == START ? DATA :
                r_state == DATA ? (r_idx == 3'(DATA_BITS - 1) ? CARRY : DATA) :
                r_state == CARRY ? STOP : IDLE;
  end
  // after a shift, bit 0 of the shift register is always the bit now on the line
  always_comb begin
    w_shreg_n = w_load ? {bus.carry, bus.sum} : w_shift ? r_shreg >> 1 : r_shreg;
    w_idx_n = w_load ? 3'd0 : w_shift ? r_idx + 3'd1 : r_idx;
    w_tx_n = (w_state_n == DATA || w_state_n == CARRY) ? w_shreg_n[0] :
             w_state_n == START ? LINE_START :
             w_state_n == STOP ? LINE_STOP : LINE_IDLE;
    w_busy_n = w_state_n != IDLE;
    w_done_n = bus.ena && r_state == STOP && w_tick;
  end
  assign bus.tx = r_tx;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
endmodule

// File: tb/tb_adder_result_uart_tx.sv
// tb_adder_result_uart_tx: table-driven frame checks plus a decoding monitor scoreboard
module tb_adder_result_uart_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;
  logic [8:0] sbq[$];
  adder_result_uart_tx_if bus();
  adder_result_uart_tx #(.CLKS_PER_BIT(4), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sum;
    logic carry;
    logic [10:0] frame;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] s, input logic c, input logic push);
    bus.sum = s;
    bus.carry = c;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    bus.sum = ~s;
    bus.carry = ~c;
    if (push) sbq.push_back({c, s});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " tx"}, 16'(bus.tx), 16'd1);
    chk({tag, " busy"}, 16'(bus.busy), 16'd0);
    chk({tag, " done"}, 16'(bus.done), 16'd0);
  endtask

  task automatic run_frame(input logic [7:0] s, input logic c, input logic [10:0] f, input string tag);
    send(s, c, 1'b1);
    chk({tag, " busy0"}, 16'(bus.busy), 16'd1);
    step(2);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) step(4);
      chk($sformatf("%s bit%0d", tag, i), 16'(bus.tx), 16'(f[i]));
      chk($sformatf("%s busy%0d", tag, i), 16'(bus.busy), 16'd1);
    end
    step(2);
    chk({tag, " done"}, 16'(bus.done), 16'd1);
    chk({tag, " busy end"}, 16'(bus.busy), 16'd0);
    chk({tag, " tx end"}, 16'(bus.tx), 16'd1);
    step(1);
    chk({tag, " done off"}, 16'(bus.done), 16'd0);
  endtask

  initial begin : monitor
    logic [10:0] b;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && bus.tx === 1'b0) begin
        repeat (2) @(negedge clk);
        b[0] = bus.tx;
        for (int i = 1; i < 11; i++) begin
          repeat (4) @(negedge clk);
          b[i] = bus.tx;
        end
        chk("mon start", 16'(b[0]), 16'd0);
        chk("mon stop", 16'(b[10]), 16'd1);
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon unexpected frame got %0h", b[9:1]);
        end else chk("mon frame", 16'(b[9:1]), 16'(sbq.pop_front()));
      end
    end
  end

  initial begin : main
    vec_t vt[5];
    vt[0] = '{8'h01, 1'b0, 11'h402};
    vt[1] = '{8'h00, 1'b1, 11'h600};
    vt[2] = '{8'h5A, 1'b1, 11'h6B4};
    vt[3] = '{8'hFF, 1'b1, 11'h7FE};
    vt[4] = '{8'hAA, 1'b0, 11'h554};
    bus.ena = 1'b1;
    bus.start = 1'b0;
    bus.sum = 8'h00;
    bus.carry = 1'b0;
    step(2);
    chk_idle("reset");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk_idle($sformatf("idle%0d", i));
    end
    bus.ena = 1'b0;
    send(8'h77, 1'b1, 1'b0);
    bus.ena = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk_idle($sformatf("ena0 start%0d", i));
    end
    mon_en = 1'b1;
    for (int v = 0; v < 5; v++) run_frame(vt[v].sum, vt[v].carry, vt[v].frame, $sformatf("v%0d", v));
    // start while busy is ignored, then a start aligned with done chains with no gap
    send(8'hFF, 1'b0, 1'b1);
    step(20);
    bus.sum = 8'h10;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    chk("busy ignore", 16'(bus.busy), 16'd1);
    step(22);
    bus.sum = 8'h3C;
    bus.carry = 1'b1;
    bus.start = 1'b1;
    sbq.push_back(9'h13C);
    step(1);
    bus.start = 1'b0;
    chk("b2b done", 16'(bus.done), 16'd1);
    chk("b2b tx", 16'(bus.tx), 16'd0);
    chk("b2b busy", 16'(bus.busy), 16'd1);
    step(44);
    chk("b2b done2", 16'(bus.done), 16'd1);
    chk("b2b busy2", 16'(bus.busy), 16'd0);
    step(1);
    mon_en = 1'b0;
    send(8'h55, 1'b0, 1'b0);
    step(15);
    bus.ena = 1'b0;
    step(1);
    chk_idle("abort");
    bus.ena = 1'b1;
    begin
      logic seen_done;
      seen_done = 1'b0;
      for (int i = 0; i < 50; i++) begin
        step(1);
        seen_done |= bus.done | bus.busy | ~bus.tx;
      end
      chk("abort quiet", 16'(seen_done), 16'd0);
    end
    mon_en = 1'b1;
    run_frame(8'hAA, 1'b0, 11'h554, "post abort");
    mon_en = 1'b0;
    send(8'h33, 1'b1, 1'b0);
    step(29);
    rst = 1'b1;
    step(1);
    chk_idle("mid rst");
    rst = 1'b0;
    step(2);
    chk_idle("after rst");
    mon_en = 1'b1;
    run_frame(8'hC3, 1'b1, 11'h786, "post rst");
    step(2);
    chk("scoreboard empty", 16'(sbq.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_result_uart_tx.md
Name: adder_result_uart_tx

Overview:
- Transmit end for the adder datapath: captures the adder's 8-bit sum plus carry-out and sends it off-chip as one asynchronous serial frame on a single output pin.
- Sits after the adder in the tt_um top level. `sum` comes from the adder result that drives uo_out, `carry` from the overflow bit, and `tx` is routed to a spare uio_out pin with uio_oe set.
- Lets a host read results over one wire instead of sampling eight parallel pins.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 2..65535.
- CNT_W, 16, width of the bit-period counter; must satisfy 2**CNT_W > CLKS_PER_BIT.

Ports:
- clk    in   1  system clock
- rst    in   1  synchronous, active-high reset (top level drives rst = ~rst_n)
- ena    in   1  design enable; low aborts and idles the block
- start  in   1  single-cycle request to capture and send sum/carry
- sum    in   8  adder result
- carry  in   1  adder carry-out (overflow)
- tx     out  1  serial line, idles high
- busy   out  1  high while a frame is in progress
- done   out  1  one-cycle pulse when the stop bit completes

Behaviour:
- Reset (rst=1 at a clk edge): tx=1, busy=0, done=0, state=IDLE, counters and shift register cleared. rst has priority over everything.
- Frame is 11 bits, LSB first: start(0), sum[0]..sum[7], carry, stop(1). Each bit is held for exactly CLKS_PER_BIT cycles, so a frame lasts 11*CLKS_PER_BIT cycles.
- States: IDLE, START, DATA, CARRY, STOP.
- IDLE: if ena=1 and start=1 at edge k, latch {carry,sum} into a 9-bit shift register and enter START.
  - From edge k onward (registered): tx=0 and busy=1.
  - start=1 while ena=0 is ignored.
- START: after CLKS_PER_BIT cycles go to DATA with bit index 0.
- DATA: drive shreg[0]. Each bit period, shift right and increment the index. After index 7 completes, go to CARRY.
- CARRY: drive the latched carry for one bit period, then go to STOP.
- STOP: tx=1 for one bit period. At its final edge go to IDLE, set busy=0 and pulse done=1 for exactly one cycle.
- Back-to-back frames: start=1 in the same cycle done=1 is accepted. The new frame's start bit follows immediately, with no extra idle cycle.
- start while busy=1 is ignored; the latched data is unaffected. Changes to sum/carry after capture have no effect on the frame in flight.
- ena=0 during a frame aborts it: at the next edge state=IDLE, tx=1, busy=0, done stays 0. A partial frame is not resumed.
- tx, busy and done are all register outputs; no combinational path from any input to any output.
- Bit counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.

Decomposition:
- Shared package adder_pkg holds:
  - the state enum (IDLE, START, DATA, CARRY, STOP);
  - FRAME_BITS=11 and DATA_BITS=8;
  - localparams for the idle/start/stop line levels.
- One natural sub-module: baud_tick_gen (parameter CLKS_PER_BIT). It gives a one-cycle `tick` at the end of each bit period and is cleared on frame start or abort. The FSM and shift register stay in the top module.

Test Plan (CLKS_PER_BIT=4):
- rst=1 for 2 cycles, then idle 10 cycles -> tx=1, busy=0, done=0 throughout.
- sum=0x01, carry=0, start pulse -> 44-cycle frame on tx. Bits (4 cycles each): 0, 1,0,0,0,0,0,0,0, 0, 1. busy high for 44 cycles, then done=1 for one cycle.
- sum=0x00, carry=1 (0xFF+0x01 overflow) -> data bits all 0, carry bit=1, stop=1. Sampled mid-bit, the frame decodes to {carry=1, sum=0x00}.
- sum=0xFF, carry=0, with a second start (sum=0x10) at cycle 20 -> the second start is ignored and the frame decodes to 0xFF, carry 0. A start asserted with done -> the next frame begins with no idle gap.
- Mid-frame at cycle 15 drop ena for 1 cycle -> next edge tx=1, busy=0, no done pulse. A subsequent start with sum=0xAA sends a clean frame 0,0,1,0,1,0,1,0,1,0,1.
- rst=1 at cycle 30 of a frame -> next edge all outputs at reset values. A new start afterwards sends a correct full frame.
